// File: rtl/axil_mem_responder_pkg.sv
// Shared types and constants for the AXI4-Lite memory responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axil_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;
endpackage

// File: rtl/axil_mem_responder_if.sv
// AXI4-Lite AR/R/AW/W/B channel bundle between accelerator master and memory responder.
// Latency: none (wires only).
// Backpressure: standard valid/ready on every channel.
interface axil_mem_responder_if;
  import axil_pkg::*;

  logic              ARVALID;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARREADY;
  logic              RVALID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RREADY;
  logic              AWVALID;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWREADY;
  logic              WVALID;
  logic [DATA_W-1:0] WDATA;
  logic              WREADY;
  logic              BVALID;
  logic [1:0]        BRESP;
  logic              BREADY;

  modport master (
    output ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, BREADY,
    input  ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, BREADY,
    output ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/axil_mem_responder_addr_decode.sv
// Byte address to word index decode with alignment and range check.
// Latency: combinational.
// Backpressure: none.
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_word;

  assign w_off  = i_addr - BASE_ADDR;
  assign w_word = w_off >> 2;
  assign o_idx  = w_word[IDX_W-1:0];
  // Word must be aligned, at or above the base, and inside the array.
  assign o_valid = (i_addr[1:0] == 2'b00) && (i_addr >= BASE_ADDR) && (w_word < 32'(DEPTH));

endmodule

// File: rtl/axil_mem_responder.sv
// AXI4-Lite memory slave with side-band preload/peek; optional ready stalls via `AXIL_MEM_STALL_EN.
// Latency: RVALID RD_LAT cycles after AR handshake; BVALID WR_LAT cycles after write commit.
// Backpressure: one read and one write outstanding; readies low until the response is taken.
module axil_mem_responder
  import axil_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic               ACLK,
  input  logic               ARESET,
  axil_mem_responder_if.slave s_axil,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic [IDX_W-1:0]   pk_idx,
  output logic [DATA_W-1:0]  pk_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  rd_state_e         r_rd_state;
  logic [3:0]        r_rd_cnt;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_rd_ok;
  logic              r_arready;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  wr_state_e         r_wr_state;
  logic [3:0]        r_wr_cnt;
  logic              r_aw_got;
  logic              r_w_got;
  logic [IDX_W-1:0]  r_aw_idx;
  logic              r_aw_ok;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  logic [IDX_W-1:0]  w_ar_idx;
  logic              w_ar_ok;
  logic [IDX_W-1:0]  w_aw_idx;
  logic              w_aw_ok;
  logic              w_arready;
  logic              w_awready;
  logic              w_wready;
  logic              w_ar_hs;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [IDX_W-1:0]  w_cm_idx;
  logic              w_cm_ok;
  logic [DATA_W-1:0] w_cm_data;

  axil_addr_decode #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rd_dec (
    .i_addr (s_axil.ARADDR),
    .o_idx  (w_ar_idx),
    .o_valid(w_ar_ok)
  );

  axil_addr_decode #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wr_dec (
    .i_addr (s_axil.AWADDR),
    .o_idx  (w_aw_idx),
    .o_valid(w_aw_ok)
  );

`ifdef AXIL_MEM_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) that randomly blocks idle readies.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Readies are only ever high while idle, so gating them here only stalls idle acceptance.
  assign w_arready = r_arready & ~r_lfsr[0];
  assign w_awready = r_awready & ~r_lfsr[0];
  assign w_wready  = r_wready  & ~r_lfsr[0];
`else
  assign w_arready = r_arready;
  assign w_awready = r_awready;
  assign w_wready  = r_wready;
`endif

  assign w_ar_hs = s_axil.ARVALID & w_arready;
  assign w_aw_hs = s_axil.AWVALID & w_awready;
  assign w_w_hs  = s_axil.WVALID  & w_wready;

  // Commit in the cycle the second of AW/W arrives (or both together); mux held vs live values.
  assign w_commit  = (r_wr_state == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_cm_idx  = r_aw_got ? r_aw_idx : w_aw_idx;
  assign w_cm_ok   = r_aw_got ? r_aw_ok  : w_aw_ok;
  assign w_cm_data = r_w_got  ? r_wdata  : s_axil.WDATA;

  // Read FSM: capture address, count down RD_LAT, hold the response until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= 4'd0;
      r_rd_idx   <= '0;
      r_rd_ok    <= 1'b0;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rd_idx   <= w_ar_idx;
            r_rd_ok    <= w_ar_ok;
            r_rd_cnt   <= 4'(RD_LAT - 1);
            r_arready  <= 1'b0;
            r_rd_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rd_cnt == 4'd0) begin
            // Array sampled before this edge's write lands: same-cycle commits stay invisible.
            r_rdata    <= r_rd_ok ? r_mem[r_rd_idx] : '0;
            r_rresp    <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rvalid   <= 1'b1;
            r_rd_state <= R_RESP;
          end else begin
            r_rd_cnt <= r_rd_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (s_axil.RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: gather AW and W in any order, commit, count down WR_LAT, hold B until BREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= 4'd0;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_aw_idx   <= '0;
      r_aw_ok    <= 1'b0;
      r_wdata    <= '0;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_got  <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_ok   <= w_aw_ok;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_w_got  <= 1'b1;
            r_wdata  <= s_axil.WDATA;
            r_wready <= 1'b0;
          end
          if (w_commit) begin
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bresp    <= w_cm_ok ? RESP_OKAY : RESP_SLVERR;
            r_wr_cnt   <= 4'(WR_LAT - 1);
            r_wr_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (r_wr_cnt == 4'd0) begin
            r_bvalid   <= 1'b1;
            r_wr_state <= W_RESP;
          end else begin
            r_wr_cnt <= r_wr_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (s_axil.BREADY) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Storage is never cleared; the preload port is ordered last so it wins a same-index collision.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_cm_ok && !ARESET) r_mem[w_cm_idx] <= w_cm_data;
    if (ld_en)                          r_mem[ld_idx]   <= ld_data;
  end

  assign pk_data        = r_mem[pk_idx];
  assign s_axil.ARREADY = w_arready;
  assign s_axil.RVALID  = r_rvalid;
  assign s_axil.RDATA   = r_rdata;
  assign s_axil.RRESP   = r_rresp;
  assign s_axil.AWREADY = w_awready;
  assign s_axil.WREADY  = w_wready;
  assign s_axil.BVALID  = r_bvalid;
  assign s_axil.BRESP   = r_bresp;

endmodule

// File: tb/tb_axil_mem_responder.sv
// Self-checking bench for axil_mem_responder against a word-array reference model.
// Latency: checks RD_LAT / WR_LAT response timing.
// Backpressure: exercises held RREADY and split AW/W arrival.
module tb_axil_mem_responder;
  import axil_pkg::*;

  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic        ACLK   = 1'b0;
  logic        ARESET = 1'b1;
  logic        ld_en  = 1'b0;
  logic [7:0]  ld_idx = 8'd0;
  logic [31:0] ld_data = 32'd0;
  logic [7:0]  pk_idx = 8'd0;
  logic [31:0] pk_data;

  axil_mem_responder_if bus();

  axil_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s_axil (bus),
    .ld_en  (ld_en),
    .ld_idx (ld_idx),
    .ld_data(ld_data),
    .pk_idx (pk_idx),
    .pk_data(pk_data)
  );

  always #5 ACLK = ~ACLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_mem [DEPTH];

  // Reference decode: aligned, not below base, word offset inside the array.
  function automatic bit m_ok(logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && ((a - BASE) / 4 < DEPTH);
  endfunction

  function automatic int m_idx(logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ld_word(input int idx, input logic [31:0] d);
    logic [31:0] iv;
    iv      = idx;
    ld_en   = 1'b1;
    ld_idx  = iv[7:0];
    ld_data = d;
    tick();
    ld_en = 1'b0;
    exp_mem[idx] = d;
  endtask

  task automatic axi_read(input logic [31:0] a, input bit auto_ack,
                          output logic [31:0] d, output logic [1:0] r, output int lat);
    int g;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    g = 0;
    while (!bus.ARREADY && g < 100) begin tick(); g++; end
    tick();
    bus.ARVALID = 1'b0;
    lat = 0;
    while (!bus.RVALID && lat < 100) begin tick(); lat++; end
    n_vec++;
    if (!bus.RVALID) begin
      n_err++;
      $display("FAIL rd_timeout addr=%h: RVALID=%b, required 1", a, bus.RVALID);
    end
    d = bus.RDATA;
    r = bus.RRESP;
    if (auto_ack) begin
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
    end
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: together.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int lead,
                           output logic [1:0] r, output int lat);
    int aw_at, w_at, cyc;
    bit aw_d, w_d, awf, wf;
    aw_at = (lead >= 0) ? lead : 0;
    w_at  = (lead >= 0) ? 0 : -lead;
    aw_d = 0; w_d = 0; cyc = 0;
    while (!(aw_d && w_d) && cyc < 200) begin
      bus.AWADDR  = a;
      bus.WDATA   = d;
      bus.AWVALID = !aw_d && (cyc >= aw_at);
      bus.WVALID  = !w_d && (cyc >= w_at);
      awf = bus.AWVALID && bus.AWREADY;
      wf  = bus.WVALID && bus.WREADY;
      tick();
      if (awf) aw_d = 1;
      if (wf)  w_d = 1;
      cyc++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    lat = 0;
    while (!bus.BVALID && lat < 100) begin tick(); lat++; end
    n_vec++;
    if (!bus.BVALID) begin
      n_err++;
      $display("FAIL wr_timeout addr=%h: BVALID=%b, required 1", a, bus.BVALID);
    end
    r = bus.BRESP;
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID} !== 5'b11100) begin
      n_err++;
      $display("FAIL reset_ctl: got %b, required 11100",
               {bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID});
    end
    n_vec++;
    if ({bus.RDATA, bus.RRESP, bus.BRESP} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_dat: got %h, required 0", {bus.RDATA, bus.RRESP, bus.BRESP});
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) ld_word(i, $urandom);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = $urandom_range(0, DEPTH - 1);
      pk_idx = 8'(i);
      #1;
      n_vec++;
      if (pk_data !== exp_mem[i]) begin
        n_err++;
        $display("FAIL peek idx=%0d: got %h, required %h", i, pk_data, exp_mem[i]);
      end
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] d; logic [1:0] r; int lat;
    ld_word(3, 32'hDEAD_BEEF);
    axi_read(32'h0C, 1, d, r, lat);
    n_vec++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      n_err++;
      $display("FAIL read_basic: got %h/%b, required deadbeef/00", d, r);
    end
    n_vec++;
    if (lat !== RD_LAT) begin
      n_err++;
      $display("FAIL read_lat: got %0d, required %0d", lat, RD_LAT);
    end
  endtask

  task automatic test_write_w_first();
    logic [1:0] r; int lat;
    axi_write(32'h10, 32'h1234_5678, 3, r, lat);
    exp_mem[4] = 32'h1234_5678;
    n_vec++;
    if (r !== 2'b00 || lat !== WR_LAT) begin
      n_err++;
      $display("FAIL write_w_first: got resp %b lat %0d, required 00 lat %0d", r, lat, WR_LAT);
    end
    for (int i = 3; i <= 5; i++) begin
      pk_idx = 8'(i);
      #1;
      n_vec++;
      if (pk_data !== exp_mem[i]) begin
        n_err++;
        $display("FAIL write_peek idx=%0d: got %h, required %h", i, pk_data, exp_mem[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] d; logic [1:0] r; int lat;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0402;
    addrs[1] = 32'h0000_0400;
    for (int k = 0; k < 2; k++) begin
      axi_read(addrs[k], 1, d, r, lat);
      n_vec++;
      if (d !== 32'h0 || r !== 2'b10) begin
        n_err++;
        $display("FAIL read_invalid addr=%h: got %h/%b, required 0/10", addrs[k], d, r);
      end
    end
    axi_write(32'h400, ~exp_mem[0], 0, r, lat);
    n_vec++;
    if (r !== 2'b10) begin
      n_err++;
      $display("FAIL write_invalid: got resp %b, required 10", r);
    end
    pk_idx = 8'd0;
    #1;
    n_vec++;
    if (pk_data !== exp_mem[0]) begin
      n_err++;
      $display("FAIL write_invalid_mem: got %h, required %h", pk_data, exp_mem[0]);
    end
  endtask

  task automatic test_rready_hold();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_read(32'h0C, 0, d, r, lat);
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_mem[3] || bus.ARREADY !== 1'b0) begin
        n_err++;
        $display("FAIL rready_hold c=%0d: got v=%b d=%h ar=%b, required 1/%h/0",
                 c, bus.RVALID, bus.RDATA, bus.ARREADY, exp_mem[3]);
      end
      tick();
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    n_vec++;
    if (bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0) begin
      n_err++;
      $display("FAIL rready_release: got ar=%b v=%b, required 1/0", bus.ARREADY, bus.RVALID);
    end
  endtask

  task automatic test_ld_collision();
    int g;
    bus.AWADDR  = 32'h1C;
    bus.WDATA   = 32'h5555_5555;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    ld_en   = 1'b1;
    ld_idx  = 8'd7;
    ld_data = 32'hAAAA_AAAA;
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    ld_en = 1'b0;
    exp_mem[7] = 32'hAAAA_AAAA;
    g = 0;
    while (!bus.BVALID && g < 100) begin tick(); g++; end
    n_vec++;
    if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00) begin
      n_err++;
      $display("FAIL ld_collision_resp: got v=%b resp=%b, required 1/00", bus.BVALID, bus.BRESP);
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    pk_idx = 8'd7;
    #1;
    n_vec++;
    if (pk_data !== exp_mem[7]) begin
      n_err++;
      $display("FAIL ld_collision_mem: got %h, required %h", pk_data, exp_mem[7]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.ARADDR  = 32'h0C;
    bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    ARESET = 1'b1;
    tick();
    n_vec++;
    if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b ar=%b, required 0/1", bus.RVALID, bus.ARREADY);
    end
    ARESET = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (bus.RVALID !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abandon: got RVALID=%b, required 0", bus.RVALID);
    end
    axi_read(32'h10, 1, d, r, lat);
    n_vec++;
    if (d !== exp_mem[4] || r !== 2'b00 || lat !== RD_LAT) begin
      n_err++;
      $display("FAIL reset_recover: got %h/%b lat %0d, required %h/00 lat %0d",
               d, r, lat, exp_mem[4], RD_LAT);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      logic [31:0] a, d, wd, ed; logic [1:0] r, er; int lat, k, idx;
      k   = $urandom_range(0, 9);
      idx = $urandom_range(0, DEPTH - 1);
      if (k < 7)      a = BASE + 32'(idx) * 4;
      else if (k < 8) a = BASE + 32'(idx) * 4 + 32'($urandom_range(1, 3));
      else            a = BASE + 32'(DEPTH + $urandom_range(0, 255)) * 4;
      er = m_ok(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        axi_read(a, 1, d, r, lat);
        ed = m_ok(a) ? exp_mem[m_idx(a)] : 32'h0;
        n_vec++;
        if (d !== ed || r !== er || lat !== RD_LAT) begin
          n_err++;
          $display("FAIL rand_read addr=%h: got %h/%b lat %0d, required %h/%b lat %0d",
                   a, d, r, lat, ed, er, RD_LAT);
        end
      end else begin
        wd = $urandom;
        axi_write(a, wd, $urandom_range(0, 6) - 3, r, lat);
        if (m_ok(a)) exp_mem[m_idx(a)] = wd;
        n_vec++;
        if (r !== er || lat !== WR_LAT) begin
          n_err++;
          $display("FAIL rand_write addr=%h: got %b lat %0d, required %b lat %0d",
                   a, r, lat, er, WR_LAT);
        end
        pk_idx = 8'(idx);
        #1;
        n_vec++;
        if (pk_data !== exp_mem[idx]) begin
          n_err++;
          $display("FAIL rand_peek idx=%0d: got %h, required %h", idx, pk_data, exp_mem[idx]);
        end
      end
    end
  endtask

  initial begin
    bus.ARVALID = 1'b0; bus.ARADDR = 32'h0; bus.RREADY = 1'b0;
    bus.AWVALID = 1'b0; bus.AWADDR = 32'h0; bus.WVALID = 1'b0;
    bus.WDATA   = 32'h0; bus.BREADY = 1'b0;
    test_reset();
    test_preload();
    test_read_basic();
    test_write_w_first();
    test_invalid();
    test_rready_hold();
    test_ld_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
